// File: rtl/tsc_ctrl_pkg.sv
// Shared encodings for the TSC multi-cycle controller: opcodes, func codes,
// FSM states, datapath select values and the control/class bundles.
package tsc_ctrl_pkg;

    localparam int unsigned OP_WIDTH   = 4;
    localparam int unsigned FUNC_WIDTH = 6;

    localparam logic [OP_WIDTH-1:0] OP_BNE   = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_BGZ   = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_BLZ   = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_ADI   = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_ORI   = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_LHI   = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_LWD   = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_SWD   = 4'd8;
    localparam logic [OP_WIDTH-1:0] OP_JMP   = 4'd9;
    localparam logic [OP_WIDTH-1:0] OP_JAL   = 4'd10;
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 4'd15;

    localparam logic [FUNC_WIDTH-1:0] FN_ADD = 6'd0;
    localparam logic [FUNC_WIDTH-1:0] FN_SUB = 6'd1;
    localparam logic [FUNC_WIDTH-1:0] FN_AND = 6'd2;
    localparam logic [FUNC_WIDTH-1:0] FN_ORR = 6'd3;
    localparam logic [FUNC_WIDTH-1:0] FN_NOT = 6'd4;
    localparam logic [FUNC_WIDTH-1:0] FN_TCP = 6'd5;
    localparam logic [FUNC_WIDTH-1:0] FN_SHL = 6'd6;
    localparam logic [FUNC_WIDTH-1:0] FN_SHR = 6'd7;
    localparam logic [FUNC_WIDTH-1:0] FN_JPR = 6'd25;
    localparam logic [FUNC_WIDTH-1:0] FN_JRL = 6'd26;
    localparam logic [FUNC_WIDTH-1:0] FN_WWD = 6'd28;
    localparam logic [FUNC_WIDTH-1:0] FN_HLT = 6'd29;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG    = 2'b11;

    localparam logic [1:0] ASB_REG = 2'b00;
    localparam logic [1:0] ASB_ONE = 2'b01;
    localparam logic [1:0] ASB_IMM = 2'b10;

    localparam logic [1:0] RDST_RT   = 2'b00;
    localparam logic [1:0] RDST_RD   = 2'b01;
    localparam logic [1:0] RDST_LINK = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic branch;
        logic load;
        logic store;
        logic jmp;
        logic jal;
        logic jpr;
        logic jrl;
        logic wwd;
        logic hlt;
        logic illegal;
    } inst_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       aluout_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_sel;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       output_active;
    } ctrl_t;

endpackage

// File: rtl/ctrl_inst_class.sv
// Combinational opcode/func decode into a one-hot instruction class.
module ctrl_inst_class
    import tsc_ctrl_pkg::*;
(
    input  logic [OP_WIDTH-1:0]   opcode,
    input  logic [FUNC_WIDTH-1:0] func_code,
    output inst_class_t           inst_class_c
);

    always_comb begin
        inst_class_c = '0;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: inst_class_c.branch = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         inst_class_c.alu_i  = 1'b1;
            OP_LWD:                         inst_class_c.load   = 1'b1;
            OP_SWD:                         inst_class_c.store  = 1'b1;
            OP_JMP:                         inst_class_c.jmp    = 1'b1;
            OP_JAL:                         inst_class_c.jal    = 1'b1;
            OP_RTYPE: begin
                case (func_code)
                    FN_ADD, FN_SUB, FN_AND, FN_ORR,
                    FN_NOT, FN_TCP, FN_SHL, FN_SHR: inst_class_c.alu_r   = 1'b1;
                    FN_JPR:                         inst_class_c.jpr     = 1'b1;
                    FN_JRL:                         inst_class_c.jrl     = 1'b1;
                    FN_WWD:                         inst_class_c.wwd     = 1'b1;
                    FN_HLT:                         inst_class_c.hlt     = 1'b1;
                    default:                        inst_class_c.illegal = 1'b1;
                endcase
            end
            default: inst_class_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the 16-bit TSC multi-cycle datapath: sequences IF/ID/EX/MEM/WB,
// handshakes with variable-latency memory and counts retired instructions.
module multicycle_control
    import tsc_ctrl_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WORD_WIDTH/4-1:0] opcode,
    input  logic [FUNC_WIDTH-1:0]   func_code,
    input  logic                    mem_ready,
    input  logic                    alu_bcond,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic [1:0]              pc_source,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    aluout_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic                    ext_sel,
    output logic                    reg_write,
    output logic [1:0]              reg_dst,
    output logic [1:0]              wb_src,
    output logic                    output_active,
    output logic                    is_halted,
    output logic [CNT_WIDTH-1:0]    num_inst
);

    state_t      state, state_nxt;
    inst_class_t cls_c;
    ctrl_t       ctl_c, ctl_g;
    logic        retire_c;

    // Branch resolution happens in the datapath via pc_write_cond.
    logic unused_bcond;
    assign unused_bcond = alu_bcond;

    ctrl_inst_class u_inst_class (
        .opcode       (opcode),
        .func_code    (func_code),
        .inst_class_c (cls_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IF;
            num_inst  <= '0;
            is_halted <= 1'b0;
        end else begin
            state <= state_nxt;
            if (retire_c) begin
                num_inst <= num_inst + CNT_WIDTH'(1);
            end
            if (state_nxt == S_HALT) begin
                is_halted <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        retire_c      = 1'b0;
        ctl_c         = '0;
        ctl_c.ext_sel = cls_c.jmp | cls_c.jal;

        case (state)
            S_IF: begin
                ctl_c.mem_read  = 1'b1;
                ctl_c.alu_src_b = ASB_ONE;
                if (mem_ready) begin
                    ctl_c.ir_write = 1'b1;
                    ctl_c.pc_write = 1'b1;
                    state_nxt      = S_ID;
                end
            end

            S_ID: begin
                // Branch target precompute happens regardless of class.
                ctl_c.alu_src_b    = ASB_IMM;
                ctl_c.aluout_write = 1'b1;
                if (cls_c.jmp) begin
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCS_JUMP;
                    retire_c        = 1'b1;
                    state_nxt       = S_IF;
                end else if (cls_c.jal) begin
                    state_nxt = S_WB;
                end else if (cls_c.hlt) begin
                    state_nxt = S_HALT;
                end else if (cls_c.illegal) begin
                    retire_c  = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    state_nxt = S_EX;
                end
            end

            S_EX: begin
                if (cls_c.alu_r) begin
                    ctl_c.alu_src_a    = 1'b1;
                    ctl_c.alu_src_b    = ASB_REG;
                    ctl_c.aluout_write = 1'b1;
                    state_nxt          = S_WB;
                end else if (cls_c.alu_i) begin
                    ctl_c.alu_src_a    = 1'b1;
                    ctl_c.alu_src_b    = ASB_IMM;
                    ctl_c.aluout_write = 1'b1;
                    state_nxt          = S_WB;
                end else if (cls_c.branch) begin
                    ctl_c.alu_src_a     = 1'b1;
                    ctl_c.alu_src_b     = ASB_REG;
                    ctl_c.pc_write_cond = 1'b1;
                    ctl_c.pc_source     = PCS_ALUOUT;
                    retire_c            = 1'b1;
                    state_nxt           = S_IF;
                end else if (cls_c.load || cls_c.store) begin
                    ctl_c.alu_src_a    = 1'b1;
                    ctl_c.alu_src_b    = ASB_IMM;
                    ctl_c.aluout_write = 1'b1;
                    state_nxt          = S_MEM;
                end else if (cls_c.jpr) begin
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCS_REG;
                    retire_c        = 1'b1;
                    state_nxt       = S_IF;
                end else if (cls_c.jrl) begin
                    state_nxt = S_WB;
                end else if (cls_c.wwd) begin
                    ctl_c.output_active = 1'b1;
                    retire_c            = 1'b1;
                    state_nxt           = S_IF;
                end else begin
                    retire_c  = 1'b1;
                    state_nxt = S_IF;
                end
            end

            S_MEM: begin
                ctl_c.i_or_d    = 1'b1;
                ctl_c.mem_read  = cls_c.load;
                ctl_c.mem_write = cls_c.store;
                if (mem_ready) begin
                    if (cls_c.store) begin
                        retire_c  = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end

            S_WB: begin
                ctl_c.reg_write = 1'b1;
                retire_c        = 1'b1;
                state_nxt       = S_IF;
                if (cls_c.load) begin
                    ctl_c.reg_dst = RDST_RT;
                    ctl_c.wb_src  = WB_MDR;
                end else if (cls_c.alu_r) begin
                    ctl_c.reg_dst = RDST_RD;
                    ctl_c.wb_src  = WB_ALUOUT;
                end else if (cls_c.jal) begin
                    ctl_c.reg_dst   = RDST_LINK;
                    ctl_c.wb_src    = WB_PC;
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCS_JUMP;
                end else if (cls_c.jrl) begin
                    ctl_c.reg_dst   = RDST_LINK;
                    ctl_c.wb_src    = WB_PC;
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCS_REG;
                end else begin
                    ctl_c.reg_dst = RDST_RT;
                    ctl_c.wb_src  = WB_ALUOUT;
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_IF;
            end
        endcase
    end

    // Reset kills every enable immediately, including an in-flight memory access.
    assign ctl_g = reset_n ? ctl_c : '0;

    assign pc_write      = ctl_g.pc_write;
    assign pc_write_cond = ctl_g.pc_write_cond;
    assign pc_source     = ctl_g.pc_source;
    assign i_or_d        = ctl_g.i_or_d;
    assign mem_read      = ctl_g.mem_read;
    assign mem_write     = ctl_g.mem_write;
    assign ir_write      = ctl_g.ir_write;
    assign aluout_write  = ctl_g.aluout_write;
    assign alu_src_a     = ctl_g.alu_src_a;
    assign alu_src_b     = ctl_g.alu_src_b;
    assign ext_sel       = ctl_g.ext_sel;
    assign reg_write     = ctl_g.reg_write;
    assign reg_dst       = ctl_g.reg_dst;
    assign wb_src        = ctl_g.wb_src;
    assign output_active = ctl_g.output_active;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance with a 4-bit counter
// exercises counter wrap-around within a short run.
module tb_multicycle_control;

    logic        clk;
    logic        reset_n;
    logic        mem_ready;
    logic        alu_bcond;
    logic [15:0] fetch_word;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [5:0]  func_code;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        aluout_write, alu_src_a, ext_sel, reg_write, output_active, is_halted;
    logic [1:0]  pc_source, alu_src_b, reg_dst, wb_src;
    logic [15:0] num_inst;

    logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
    logic        w_aluout_write, w_alu_src_a, w_ext_sel, w_reg_write, w_output_active, w_is_halted;
    logic [1:0]  w_pc_source, w_alu_src_b, w_reg_dst, w_wb_src;
    logic [3:0]  w_num_inst;

    logic [18:0] obs, obs4;
    logic [15:0] exp_cnt;
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction register model fed by the fetch word.
    initial ir = 16'h0000;
    always @(posedge clk) if (ir_write) ir <= fetch_word;
    assign opcode    = ir[15:12];
    assign func_code = ir[5:0];

    assign obs  = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   aluout_write, alu_src_a, alu_src_b, ext_sel, reg_write, reg_dst, wb_src,
                   output_active};
    assign obs4 = {w_pc_write, w_pc_write_cond, w_pc_source, w_i_or_d, w_mem_read, w_mem_write,
                   w_ir_write, w_aluout_write, w_alu_src_a, w_alu_src_b, w_ext_sel, w_reg_write,
                   w_reg_dst, w_wb_src, w_output_active};

    multicycle_control u_dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
        .mem_ready(mem_ready), .alu_bcond(alu_bcond),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .aluout_write(aluout_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_sel(ext_sel), .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
        .output_active(output_active), .is_halted(is_halted), .num_inst(num_inst)
    );

    multicycle_control #(.CNT_WIDTH(4)) u_dut_w4 (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
        .mem_ready(mem_ready), .alu_bcond(alu_bcond),
        .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_source(w_pc_source),
        .i_or_d(w_i_or_d), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .ir_write(w_ir_write), .aluout_write(w_aluout_write), .alu_src_a(w_alu_src_a),
        .alu_src_b(w_alu_src_b), .ext_sel(w_ext_sel), .reg_write(w_reg_write),
        .reg_dst(w_reg_dst), .wb_src(w_wb_src), .output_active(w_output_active),
        .is_halted(w_is_halted), .num_inst(w_num_inst)
    );

    // Expected control vectors, same bit order as obs.
    function automatic logic [18:0] v_if(input logic rdy, input logic e);
        return {rdy, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 2'b01, e, 1'b0,
                2'b00, 2'b00, 1'b0};
    endfunction

    function automatic logic [18:0] v_id(input logic e, input logic jmp);
        return {jmp, 1'b0, jmp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, e, 1'b0,
                2'b00, 2'b00, 1'b0};
    endfunction

    function automatic logic [18:0] v_ex(input logic asa, input logic [1:0] asb,
                                         input logic aow, input logic pcw, input logic pcwc,
                                         input logic [1:0] pcs, input logic oa);
        return {pcw, pcwc, pcs, 1'b0, 1'b0, 1'b0, 1'b0, aow, asa, asb, 1'b0, 1'b0,
                2'b00, 2'b00, oa};
    endfunction

    function automatic logic [18:0] v_mem(input logic mr, input logic mw);
        return {1'b0, 1'b0, 2'b00, 1'b1, mr, mw, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
                2'b00, 2'b00, 1'b0};
    endfunction

    function automatic logic [18:0] v_wb(input logic [1:0] rd, input logic [1:0] wb,
                                         input logic pcw, input logic [1:0] pcs,
                                         input logic e);
        return {pcw, 1'b0, pcs, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, e, 1'b1,
                rd, wb, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; alu_bcond = 1'b0; fetch_word = 16'h0000;
        tick();
        tick();
        total++;
        if (obs !== 19'h0) begin bad++; $display("FAIL reset_ctl got=%h want=%h", obs, 19'h0); end
        total++;
        if (num_inst !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", num_inst); end
        total++;
        if (is_halted !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b want=0", is_halted); end
        total++;
        if (w_num_inst !== 4'h0) begin bad++; $display("FAIL reset_cnt4 got=%h want=0", w_num_inst); end
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== v_if(1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_if_wait got=%h want=%h", obs, v_if(1'b0, 1'b0));
        end
        tick();
        exp_cnt = 16'h0;
    endtask

    task automatic test_adi();
        logic [18:0] ev [4];
        ev[0] = v_if(1'b1, 1'b0);
        ev[1] = v_id(1'b0, 1'b0);
        ev[2] = v_ex(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        ev[3] = v_wb(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
        fetch_word = 16'h4105; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== ev[i]) begin bad++; $display("FAIL adi_c%0d got=%h want=%h", i, obs, ev[i]); end
            total++;
            if (num_inst !== exp_cnt) begin bad++; $display("FAIL adi_cnt%0d got=%h want=%h", i, num_inst, exp_cnt); end
            tick();
        end
        exp_cnt++;
        total++;
        if (num_inst !== exp_cnt) begin bad++; $display("FAIL adi_retire got=%h want=%h", num_inst, exp_cnt); end
    endtask

    task automatic test_lwd();
        logic [18:0] ev [8];
        logic        rdy [8];
        ev[0] = v_if(1'b1, 1'b0);                                       rdy[0] = 1'b1;
        ev[1] = v_id(1'b0, 1'b0);                                       rdy[1] = 1'b1;
        ev[2] = v_ex(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);       rdy[2] = 1'b1;
        for (int i = 3; i < 7; i++) begin ev[i] = v_mem(1'b1, 1'b0); rdy[i] = (i == 6); end
        ev[7] = v_wb(2'b00, 2'b01, 1'b0, 2'b00, 1'b0);                  rdy[7] = 1'b1;
        fetch_word = 16'h7208;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (obs !== ev[i]) begin bad++; $display("FAIL lwd_c%0d got=%h want=%h", i, obs, ev[i]); end
            total++;
            if (num_inst !== exp_cnt) begin bad++; $display("FAIL lwd_cnt%0d got=%h want=%h", i, num_inst, exp_cnt); end
            tick();
        end
        exp_cnt++;
        total++;
        if (num_inst !== exp_cnt) begin bad++; $display("FAIL lwd_retire got=%h want=%h", num_inst, exp_cnt); end
    endtask

    task automatic test_branch();
        logic [18:0] ev [6];
        logic        bc [6];
        for (int k = 0; k < 2; k++) begin
            ev[3*k]   = v_if(1'b1, 1'b0);
            ev[3*k+1] = v_id(1'b0, 1'b0);
            ev[3*k+2] = v_ex(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
            for (int j = 0; j < 3; j++) bc[3*k+j] = (k == 0);
        end
        fetch_word = 16'h1234; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alu_bcond = bc[i];
            #1;
            total++;
            if (obs !== ev[i]) begin bad++; $display("FAIL beq_c%0d got=%h want=%h", i, obs, ev[i]); end
            total++;
            if (num_inst !== exp_cnt) begin bad++; $display("FAIL beq_cnt%0d got=%h want=%h", i, num_inst, exp_cnt); end
            tick();
            if (i == 2 || i == 5) exp_cnt++;
        end
        alu_bcond = 1'b0;
        total++;
        if (num_inst !== exp_cnt) begin bad++; $display("FAIL beq_retire got=%h want=%h", num_inst, exp_cnt); end
    endtask

    task automatic test_jal_jmp();
        logic [18:0] ev [5];
        logic [15:0] wd [5];
        ev[0] = v_if(1'b1, 1'b0);                          wd[0] = 16'hA123;
        ev[1] = v_id(1'b1, 1'b0);                          wd[1] = 16'hA123;
        ev[2] = v_wb(2'b10, 2'b10, 1'b1, 2'b10, 1'b1);     wd[2] = 16'hA123;
        ev[3] = v_if(1'b1, 1'b1);                          wd[3] = 16'h9FFF;
        ev[4] = v_id(1'b1, 1'b1);                          wd[4] = 16'h9FFF;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_word = wd[i];
            #1;
            total++;
            if (obs !== ev[i]) begin bad++; $display("FAIL jal_jmp_c%0d got=%h want=%h", i, obs, ev[i]); end
            total++;
            if (num_inst !== exp_cnt) begin bad++; $display("FAIL jal_jmp_cnt%0d got=%h want=%h", i, num_inst, exp_cnt); end
            tick();
            if (i == 2 || i == 4) exp_cnt++;
        end
        total++;
        if (num_inst !== exp_cnt) begin bad++; $display("FAIL jal_jmp_retire got=%h want=%h", num_inst, exp_cnt); end
    endtask

    task automatic test_rtype();
        logic [18:0] ev [13];
        logic [15:0] wd [13];
        logic        rt [13];
        ev[0]  = v_if(1'b1, 1'b1);                                        wd[0]  = 16'hF1C0;
        ev[1]  = v_id(1'b0, 1'b0);                                        wd[1]  = 16'hF1C0;
        ev[2]  = v_ex(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);        wd[2]  = 16'hF1C0;
        ev[3]  = v_wb(2'b01, 2'b00, 1'b0, 2'b00, 1'b0);                   wd[3]  = 16'hF1C0;
        ev[4]  = v_if(1'b1, 1'b0);                                        wd[4]  = 16'hF019;
        ev[5]  = v_id(1'b0, 1'b0);                                        wd[5]  = 16'hF019;
        ev[6]  = v_ex(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);        wd[6]  = 16'hF019;
        ev[7]  = v_if(1'b1, 1'b0);                                        wd[7]  = 16'hF01A;
        ev[8]  = v_id(1'b0, 1'b0);                                        wd[8]  = 16'hF01A;
        ev[9]  = 19'h0;                                                   wd[9]  = 16'hF01A;
        ev[10] = v_wb(2'b10, 2'b10, 1'b1, 2'b11, 1'b0);                   wd[10] = 16'hF01A;
        ev[11] = v_if(1'b1, 1'b0);                                        wd[11] = 16'hB000;
        ev[12] = v_id(1'b0, 1'b0);                                        wd[12] = 16'hB000;
        for (int i = 0; i < 13; i++) rt[i] = (i == 3 || i == 6 || i == 10 || i == 12);
        mem_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            fetch_word = wd[i];
            #1;
            total++;
            if (obs !== ev[i]) begin bad++; $display("FAIL rtype_c%0d got=%h want=%h", i, obs, ev[i]); end
            total++;
            if (num_inst !== exp_cnt) begin bad++; $display("FAIL rtype_cnt%0d got=%h want=%h", i, num_inst, exp_cnt); end
            tick();
            if (rt[i]) exp_cnt++;
        end
        total++;
        if (num_inst !== exp_cnt) begin bad++; $display("FAIL rtype_retire got=%h want=%h", num_inst, exp_cnt); end
    endtask

    task automatic test_wwd_wrap();
        logic [18:0] ev [3];
        int          n;
        int          pulses;
        ev[0] = v_if(1'b1, 1'b0);
        ev[1] = v_id(1'b0, 1'b0);
        ev[2] = v_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        n = 16 + int'(4'hF - exp_cnt[3:0]);
        pulses = 0;
        fetch_word = 16'hF01C; mem_ready = 1'b1;
        for (int k = 0; k <= n; k++) begin
            for (int i = 0; i < 3; i++) begin
                #1;
                total++;
                if (obs !== ev[i]) begin bad++; $display("FAIL wwd%0d_c%0d got=%h want=%h", k, i, obs, ev[i]); end
                total++;
                if (obs4 !== ev[i]) begin bad++; $display("FAIL wwd%0d_c%0d_w4 got=%h want=%h", k, i, obs4, ev[i]); end
                if (output_active === 1'b1) pulses++;
                tick();
            end
            exp_cnt++;
            if (k == n - 1) begin
                total++;
                if (w_num_inst !== 4'hF) begin bad++; $display("FAIL wrap_top got=%h want=f", w_num_inst); end
            end
        end
        total++;
        if (w_num_inst !== 4'h0) begin bad++; $display("FAIL wrap_zero got=%h want=0", w_num_inst); end
        total++;
        if (num_inst !== exp_cnt) begin bad++; $display("FAIL wwd_cnt got=%h want=%h", num_inst, exp_cnt); end
        total++;
        if (pulses != n + 1) begin bad++; $display("FAIL wwd_pulses got=%0d want=%0d", pulses, n + 1); end
    endtask

    task automatic test_halt();
        fetch_word = 16'hF01D; mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== v_if(1'b1, 1'b0)) begin bad++; $display("FAIL hlt_if got=%h want=%h", obs, v_if(1'b1, 1'b0)); end
        tick();
        total++;
        if (obs !== v_id(1'b0, 1'b0)) begin bad++; $display("FAIL hlt_id got=%h want=%h", obs, v_id(1'b0, 1'b0)); end
        total++;
        if (is_halted !== 1'b0) begin bad++; $display("FAIL hlt_early got=%b want=0", is_halted); end
        tick();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (obs !== 19'h0) begin bad++; $display("FAIL halt_ctl%0d got=%h want=0", i, obs); end
            total++;
            if (is_halted !== 1'b1) begin bad++; $display("FAIL halt_flag%0d got=%b want=1", i, is_halted); end
            total++;
            if (num_inst !== exp_cnt) begin bad++; $display("FAIL halt_cnt%0d got=%h want=%h", i, num_inst, exp_cnt); end
            tick();
        end
        reset_n = 1'b0;
        tick();
        exp_cnt = 16'h0;
        total++;
        if (is_halted !== 1'b0) begin bad++; $display("FAIL halt_rst_flag got=%b want=0", is_halted); end
        total++;
        if (num_inst !== 16'h0) begin bad++; $display("FAIL halt_rst_cnt got=%h want=0", num_inst); end
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== v_if(1'b0, 1'b0)) begin bad++; $display("FAIL halt_rst_if got=%h want=%h", obs, v_if(1'b0, 1'b0)); end
        tick();
    endtask

    task automatic test_reset_mem();
        logic [18:0] ev [4];
        ev[0] = v_if(1'b1, 1'b0);
        ev[1] = v_id(1'b0, 1'b0);
        ev[2] = v_ex(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        ev[3] = v_mem(1'b1, 1'b0);
        fetch_word = 16'h7208;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            #1;
            total++;
            if (obs !== ev[i]) begin bad++; $display("FAIL rstmem_c%0d got=%h want=%h", i, obs, ev[i]); end
            if (i < 3) tick();
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (mem_read !== 1'b0) begin bad++; $display("FAIL rstmem_read got=%b want=0", mem_read); end
        total++;
        if (obs !== 19'h0) begin bad++; $display("FAIL rstmem_ctl got=%h want=0", obs); end
        tick();
        reset_n = 1'b1;
        #1;
        total++;
        if (obs !== v_if(1'b0, 1'b0)) begin bad++; $display("FAIL rstmem_if got=%h want=%h", obs, v_if(1'b0, 1'b0)); end
        total++;
        if (num_inst !== 16'h0) begin bad++; $display("FAIL rstmem_cnt got=%h want=0", num_inst); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = 16'h0;
        test_reset();
        test_adi();
        test_lwd();
        test_branch();
        test_jal_jmp();
        test_rtype();
        test_wwd_wrap();
        test_halt();
        test_reset_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Microcoded-style Moore/Mealy FSM that sequences the 16-bit TSC multi-cycle datapath: instruction fetch, decode, execute, memory access and write-back.
- Drives every datapath enable and mux select: PC, IR, register file, ALU operand muxes and memory.
- Drives the immediate-format select consumed by the sign-extend unit.
- Handshakes with a variable-latency unified memory.
- Counts retired instructions.

Parameters:
- WORD_WIDTH, 16, instruction/data word width (fixed ISA width; exposed for documentation only).
- CNT_WIDTH, 16, width of retired-instruction counter num_inst.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  4  IR[15:12], valid from cycle after ir_write.
- func_code  in  6  IR[5:0].
- mem_ready  in  1  memory completed current read/write this cycle.
- alu_bcond  in  1  branch condition result from ALU (valid in EX).
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by alu_bcond.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[15:12],IR[11:0]}, 11 register rs.
- i_or_d  out  1  0 memory address = PC, 1 = ALUOut.
- mem_read  out  1  memory read request, held until mem_ready.
- mem_write  out  1  memory write request, held until mem_ready.
- ir_write  out  1  latch instruction register.
- aluout_write  out  1  latch ALUOut.
- alu_src_a  out  1  0 PC, 1 register A.
- alu_src_b  out  2  00 register B, 01 constant 1, 10 sign-extended immediate.
- ext_sel  out  1  1 selects 12-bit immediate field, 0 selects 8-bit field.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $2 (link).
- wb_src  out  2  00 ALUOut, 01 MDR, 10 PC (link).
- output_active  out  1  WWD output-port strobe.
- is_halted  out  1  sticky halt flag.
- num_inst  out  CNT_WIDTH  retired instruction count.

Behaviour:
- Reset:
  - clk edge with reset_n=0: state<=S_IF, num_inst<=0, is_halted<=0.
  - While reset_n=0, all control outputs are forced 0.
  - Reset mid-memory-wait abandons the access; mem_read/mem_write drop the same cycle.
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT.
- ext_sel is combinational from opcode: 1 iff opcode is 9 (JMP) or 10 (JAL); independent of state.
- S_IF:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_source=00.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC<=PC+1), then -> S_ID.
- S_ID:
  - Outputs: alu_src_a=0, alu_src_b=10, aluout_write=1 (branch target precompute).
  - Exits:
    - JMP: pc_write=1, pc_source=10, retire -> S_IF.
    - JAL -> S_WB.
    - HLT (op 15, func 29) -> S_HALT.
    - Undefined opcode/func: retire as NOP -> S_IF.
    - Others -> S_EX.
- S_EX:
  - R-type ALU / ADI / ORI / LHI: alu_src_a=1, alu_src_b=00 (R) or 10 (imm), aluout_write=1 -> S_WB.
  - Branches (op 0-3): alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01, retire -> S_IF.
  - LWD/SWD: alu_src_a=1, alu_src_b=10, aluout_write=1 -> S_MEM.
  - JPR: pc_write=1, pc_source=11, retire -> S_IF.
  - JRL -> S_WB.
  - WWD: output_active=1 for exactly one cycle, retire -> S_IF.
- S_MEM:
  - Outputs: i_or_d=1; LWD drives mem_read=1, SWD drives mem_write=1.
  - Holds until mem_ready.
  - Exits: LWD -> S_WB; SWD retires -> S_IF.
- S_WB: reg_write=1 for exactly one cycle, with selects:
  - LWD: reg_dst=00, wb_src=01.
  - ADI/ORI/LHI: reg_dst=00, wb_src=00.
  - R-type: reg_dst=01, wb_src=00.
  - JAL: reg_dst=10, wb_src=10, plus pc_write=1, pc_source=10.
  - JRL: reg_dst=10, wb_src=10, plus pc_write=1, pc_source=11.
  - All retire -> S_IF.
- Retirement: num_inst increments by 1 on the retiring cycle; wraps all-ones -> 0.
- S_HALT:
  - Absorbing; is_halted=1 from the first S_HALT cycle until reset.
  - HLT is not counted; all enables are 0.
- Control outputs not listed for a state/opcode are 0.

Decomposition:
- Shared package tsc_ctrl_pkg:
  - Opcode and func constants.
  - State encoding.
  - pc_source, alu_src_b, reg_dst and wb_src encodings.
- One sub-module, ctrl_inst_class: combinational opcode/func -> one-hot instruction class (alu_r, alu_i, branch, load, store, jmp, jal, jpr, jrl, wwd, hlt, illegal).

Test Plan:
- ADI $1,#5 with mem_ready=1 every cycle -> IF,ID,EX,WB (4 cycles); reg_write=1 only in WB with reg_dst=00, wb_src=00; num_inst 0->1.
- LWD with mem_ready low for 3 cycles in S_MEM -> mem_read/i_or_d=1 held 4 cycles, then WB with wb_src=01; total 8 cycles with IF ready immediately.
- BEQ taken (alu_bcond=1) then not taken (alu_bcond=0) -> pc_write_cond=1, pc_source=01 in EX both times; 3 cycles each; num_inst +2.
- JAL (0xA123) -> ext_sel=1 in ID/WB; WB: reg_dst=10, wb_src=10, pc_write=1, pc_source=10. JMP (0x9FFF) -> retires in ID after 2 cycles.
- HLT (0xF01D) -> S_HALT, is_halted=1 held for 20 cycles, num_inst unchanged; reset_n=0 for one edge -> is_halted=0, num_inst=0, state S_IF.
- Preload num_inst=0xFFFF via 65535 WWDs, then one more retire -> num_inst=0x0000; output_active pulses once per WWD. Separately, reset_n=0 during S_MEM wait -> mem_read=0 the same cycle, S_IF next.
